ham_tx_sched: RTL

- Round-robin scheduler that shares one Hamming(7,4) encode-and-transmit path between two 4-bit requesters.
- Accepts one nibble per frame through a valid/ready handshake and encodes it.
- Applies an optional error-injection mask, then shifts the 7-bit codeword out serially, LSB first.
- Sits between the user-input sources (switch capture, test-pattern generator) and the serial link that feeds the decoder side.

---
 rtl/ham_pkg.sv | 32 +++
 rtl/ham_rr_arb2.sv | 44 ++++
 rtl/ham_tx_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ham_pkg.sv
// Shared types, constants and the Hamming(7,4) encoder for the serial
// transmit scheduler.
package ham_pkg;

  localparam int CODE_W = 7;

  typedef logic [3:0]        nibble_t;
  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Even parity over three data bits.
  function automatic logic par3(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Hamming(7,4) encode, codeword = {d3,d2,d1,p3,d0,p2,p1}, bit0 = p1.
  function automatic code_t ham74_enc(input nibble_t d);
    logic p1;
    logic p2;
    logic p3;
    p1 = par3(d[0], d[1], d[3]);
    p2 = par3(d[0], d[2], d[3]);
    p3 = par3(d[1], d[2], d[3]);
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

endpackage

// File: rtl/ham_rr_arb2.sv
// Two-way round-robin grant. Ready for a requester depends only on the
// other requester's valid and the pointer, so there is no valid->ready
// loop on the same channel. The pointer moves to the loser on a transfer.
module ham_rr_arb2
  import ham_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic valid0_i,
  input  logic valid1_i,
  output logic ready0_o,
  output logic ready1_o,
  output logic xfer_o,
  output logic xfer_id_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant decode and pointer next-state.
  always_comb begin
    ready0_o  = en_i & (~valid1_i | ~ptr_q);
    ready1_o  = en_i & (~valid0_i |  ptr_q);
    xfer_o    = (valid0_i & ready0_o) | (valid1_i & ready1_o);
    xfer_id_o = valid1_i & ready1_o;
    ptr_d     = ptr_q;
    if (xfer_o) begin
      ptr_d = ~xfer_id_o;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; requester 0 has priority out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ham_tx_sched.sv
// Shares one Hamming(7,4) encode-and-serialise path between two nibble
// requesters. A frame is 7 bits, LSB first, each held BIT_CYCLES clocks,
// followed by a one-cycle GAP carrying the done pulse.
module ham_tx_sched
  import ham_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_data,
  output logic       req1_ready,
  input  logic [6:0] err_mask,
  output logic       tx_bit,
  output logic       tx_frame,
  output logic [6:0] code_out,
  output logic       grant_id,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] CYC_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [2:0] BIT_LAST = 3'd6;

  logic [1:0] state_q;
  logic [1:0] state_d;
  code_t      shreg_q;
  code_t      shreg_d;
  logic [7:0] cyc_q;
  logic [7:0] cyc_d;
  logic [2:0] bit_q;
  logic [2:0] bit_d;
  code_t      code_q;
  code_t      code_d;
  logic       gid_q;
  logic       gid_d;

  // Output registers, loaded from the next state so they line up with state_q.
  logic       idle_q;
  logic       idle_d;
  logic       tx_bit_q;
  logic       tx_bit_d;
  logic       tx_frame_q;
  logic       tx_frame_d;
  logic       busy_q;
  logic       busy_d;
  logic       done_q;
  logic       done_d;

  logic       xfer_s;
  logic       xfer_id_s;
  nibble_t    sel_data_s;

  ham_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (idle_q),
    .valid0_i  (req0_valid),
    .valid1_i  (req1_valid),
    .ready0_o  (req0_ready),
    .ready1_o  (req1_ready),
    .xfer_o    (xfer_s),
    .xfer_id_o (xfer_id_s)
  );

  // Nibble of whichever requester wins the transfer this cycle.
  always_comb begin
    if (xfer_id_s) begin
      sel_data_s = req1_data;
    end else begin
      sel_data_s = req0_data;
    end
  end

  // Frame FSM: accept, shift out seven held bits, then one GAP cycle.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    code_d  = code_q;
    gid_d   = gid_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          code_d  = ham74_enc(sel_data_s) ^ err_mask;
          shreg_d = ham74_enc(sel_data_s) ^ err_mask;
          gid_d   = xfer_id_s;
          cyc_d   = 8'd0;
          bit_d   = 3'd0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d   = 8'd0;
          shreg_d = {1'b0, shreg_q[6:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = 3'd0;
            state_d = ST_GAP;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = ST_SHIFT;
          end
        end else begin
          cyc_d   = cyc_q + 8'd1;
          state_d = ST_SHIFT;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode of the next state; tx_bit is forced low outside a frame.
  always_comb begin
    idle_d     = (state_d == ST_IDLE);
    tx_frame_d = (state_d == ST_SHIFT);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_GAP);
    if (state_d == ST_SHIFT) begin
      tx_bit_d = shreg_d[0];
    end else begin
      tx_bit_d = 1'b0;
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= 7'd0;
      cyc_q      <= 8'd0;
      bit_q      <= 3'd0;
      code_q     <= 7'd0;
      gid_q      <= 1'b0;
      idle_q     <= 1'b0;
      tx_bit_q   <= 1'b0;
      tx_frame_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      code_q     <= code_d;
      gid_q      <= gid_d;
      idle_q     <= idle_d;
      tx_bit_q   <= tx_bit_d;
      tx_frame_q <= tx_frame_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_bit   = tx_bit_q;
  assign tx_frame = tx_frame_q;
  assign code_out = code_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
